read_matrix: RTL and testbench
==============================

# read_matrix

AXI4 read master that fetches one NBLK×NROW×NCOL matrix of 32-bit words from memory into a register array. On `readstart` it issues one INCR burst per matrix row, captures every beat, and raises `readdone` when the last beat lands. It is the load-side counterpart of the matrix write-back path and feeds the compute core's operand matrix.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of element [0][0][0]; must be 4-byte aligned.
- `NBLK`, 4: number of blocks.
- `NROW`, 8: rows per block.
- `NCOL`, 8: words per row, which is also the beats per burst (≤256).
- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `readstart` input 1: level or pulse; sampled only in IDLE or DONE.
- `readdone` output 1: high in DONE.
- `readerr` output 1: sticky error flag for the current transfer.
- `Matrix_A` output 32×[NBLK][NROW][NCOL]: captured matrix.
- `araddr` output 32: burst start address.
- `arlen` output 8: constant NCOL-1.
- `arsize` output 3: constant 3'b010 (4 bytes).
- `arburst` output 2: constant 2'b01 (INCR).
- `arvalid` output 1: read-address valid.
- `arready` input 1: read-address ready.
- `rdata` input 32: read data.
- `rresp` input 2: read response.
- `rlast` input 1: last beat of burst.
- `rvalid` input 1: read-data valid.
- `rready` output 1: read-data ready.

## Operation
- States: IDLE, SEND_ADDR, RECV_DATA, DONE.
- IDLE, with `readstart`=1: clear the counters blk/row/col, clear `readerr`, go to SEND_ADDR.
- SEND_ADDR:
  - Drive `arvalid`=1 with `araddr` = BASE_ADDR + ((blk·NROW + row)·NCOL)·4.
  - On `arvalid && arready`: go to RECV_DATA.
  - `arvalid` and `araddr` stay stable until the handshake completes.
- RECV_DATA:
  - `rready`=1. Each `rvalid && rready` writes `rdata` to Matrix_A[blk][row][col], then increments col.
  - On col==NCOL-1: col←0. Advance row, wrapping into blk. Then go to SEND_ADDR, or to DONE if blk==NBLK-1 and row==NROW-1.
- DONE: `readdone`=1. `readstart`=1 restarts exactly as from IDLE and drops `readdone`.
- The beat counter is authoritative. If `rlast` is high at col≠NCOL-1, or low at col==NCOL-1, set `readerr`; data is still stored and the counting is unchanged.
- `rresp`≠2'b00 on any accepted beat sets `readerr`. The data is still stored.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. No 4 KB boundary check is made; the integrator places the matrix so that no row crosses a 4 KB boundary.
- Only one burst is outstanding at a time. No AR is issued until the previous burst's last beat is accepted.
- Reset values: state IDLE; `arvalid`=0, `rready`=0, `readdone`=0, `readerr`=0, `araddr`=BASE_ADDR; Matrix_A all zero; counters 0.
- Reset asserted mid-transfer returns the block to IDLE at once. Any outstanding interconnect beats are the integrator's concern.

## Timing
- All outputs are registered. `arvalid` rises the cycle after `readstart` is sampled.
- Each AR handshake takes at least 1 cycle. The first R beat can be accepted in the cycle after the AR handshake.
- A beat accepted in cycle t is visible on Matrix_A in cycle t+1.
- After the final beat, `readdone`=1 in the next cycle.
- With zero wait states a full matrix takes NBLK·NROW·(NCOL+1) cycles plus 2.
- `rready` is 0 outside RECV_DATA. Beats presented then are not accepted.

## Structure
- Shared package `axi_pkg` holds:
  - `axi_resp_t` (OKAY, EXOKAY, SLVERR, DECERR).
  - The `AXI_BURST_INCR` and `AXI_SIZE_4B` constants.
  - `rd_state_t`.
- One sub-module, `matrix_addr_gen`. It holds the blk/row/col counters and the `advance` / `row_end` / `last` flags, and computes the row address. It can be reused by the write path.

## Test plan
- Default parameters, zero-wait slave, memory word at address a = a>>2 → Matrix_A[b][r][c] = b·64 + r·8 + c. `readdone` is high in cycle 290 after start. `readerr`=0.
- `arready` held low 5 cycles per burst → `arvalid`/`araddr` stay stable throughout; data is correct; 32 AR handshakes with addresses BASE+32·k.
- Random `rvalid` gaps (50%) → identical matrix; no beat is lost or duplicated.
- SLVERR on beat [2][3][4] → `readerr`=1 and sticky until the next `readstart`. The stored value equals that beat's `rdata`.
- `rlast` asserted early at col 5 of row 0 → `readerr`=1; the counter still completes 8 beats per burst.
- `rstn` pulsed low mid-block 1 → all outputs return to reset values. A new `readstart` completes a correct read.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI read-channel types and constants shared by the matrix load and write-back paths.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    SEND_ADDR,
    RECV_DATA,
    DONE
  } rd_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/read_matrix_if.sv
// AXI4 read address and read data channels between the matrix loader and the interconnect.
interface read_matrix_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/matrix_addr_gen.sv
// blk/row/col walk over an NBLK x NROW x NCOL word matrix plus the byte address of the current row.
module matrix_addr_gen
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NBLK      = 4,
  parameter int          NROW      = 8,
  parameter int          NCOL      = 8,
  localparam int         BW        = cnt_w(NBLK),
  localparam int         RW        = cnt_w(NROW),
  localparam int         CW        = cnt_w(NCOL)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          advance,
  output logic [BW-1:0] blk,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          row_end,
  output logic          last,
  output logic [31:0]   row_addr
);

  localparam logic [BW-1:0] BLK_MAX   = BW'(NBLK - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(NROW - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(NCOL - 1);
  localparam logic [31:0]   ROW_BYTES = 32'(NCOL * 4);

  logic [31:0] addr_q;

  assign row_end  = (col == COL_MAX);
  assign last     = row_end && (row == ROW_MAX) && (blk == BLK_MAX);
  assign row_addr = addr_q;

  // Rows are contiguous, so the address BASE + ((blk*NROW+row)*NCOL)*4 is kept as a running
  // sum bumped once per row; 32-bit addition wraps modulo 2^32 by construction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk    <= '0;
      row    <= '0;
      col    <= '0;
      addr_q <= BASE_ADDR;
    end else if (clear) begin
      blk    <= '0;
      row    <= '0;
      col    <= '0;
      addr_q <= BASE_ADDR;
    end else if (advance) begin
      if (row_end) begin
        col    <= '0;
        addr_q <= addr_q + ROW_BYTES;
        if (row == ROW_MAX) begin
          row <= '0;
          blk <= (blk == BLK_MAX) ? '0 : blk + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/read_matrix.sv
// AXI4 read master loading an NBLK x NROW x NCOL matrix of 32-bit words, one INCR burst per row.
module read_matrix
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NBLK      = 4,
  parameter int          NROW      = 8,
  parameter int          NCOL      = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   readstart,
  output logic                                   readdone,
  output logic                                   readerr,
  output logic [NBLK-1:0][NROW-1:0][NCOL-1:0][31:0] Matrix_A,
  read_matrix_if.master                          axi
);

  localparam int BW = cnt_w(NBLK);
  localparam int RW = cnt_w(NROW);
  localparam int CW = cnt_w(NCOL);

  rd_state_t       state;
  logic            arvalid_q;
  logic            rready_q;
  logic            clear;
  logic            beat;
  logic [BW-1:0]   blk;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            row_end;
  logic            last;
  logic [31:0]     row_addr;

  assign clear = ((state == IDLE) || (state == DONE)) && readstart;
  assign beat  = (state == RECV_DATA) && axi.rvalid && rready_q;

  matrix_addr_gen #(
    .BASE_ADDR (BASE_ADDR),
    .NBLK      (NBLK),
    .NROW      (NROW),
    .NCOL      (NCOL)
  ) u_addr_gen (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .advance  (beat),
    .blk      (blk),
    .row      (row),
    .col      (col),
    .row_end  (row_end),
    .last     (last),
    .row_addr (row_addr)
  );

  assign axi.araddr  = row_addr;
  assign axi.arlen   = 8'(NCOL - 1);
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      readdone  <= 1'b0;
      readerr   <= 1'b0;
      Matrix_A  <= '0;
    end else begin
      if (beat) begin
        Matrix_A[blk][row][col] <= axi.rdata;
      end
      unique case (state)
        IDLE, DONE: begin
          if (readstart) begin
            state     <= SEND_ADDR;
            arvalid_q <= 1'b1;
            readdone  <= 1'b0;
            readerr   <= 1'b0;
          end
        end
        SEND_ADDR: begin
          if (axi.arready) begin
            state     <= RECV_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RECV_DATA: begin
          if (beat) begin
            // The local beat count decides burst end; rlast only cross-checks it.
            if ((axi.rresp != OKAY) || (axi.rlast != row_end)) begin
              readerr <= 1'b1;
            end
            if (row_end) begin
              rready_q <= 1'b0;
              if (last) begin
                state    <= DONE;
                readdone <= 1'b1;
              end else begin
                state     <= SEND_ADDR;
                arvalid_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_matrix.sv
// Directed bench for read_matrix against a behavioural AXI read slave returning word (addr>>2).
module tb_read_matrix;
  import axi_pkg::*;

  localparam int NBLK = 4;
  localparam int NROW = 8;
  localparam int NCOL = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic readstart = 1'b0;
  logic readdone;
  logic readerr;
  logic [NBLK-1:0][NROW-1:0][NCOL-1:0][31:0] mat;

  int vecs = 0;
  int errs = 0;

  // Slave knobs and observations
  int ar_wait = 0;
  bit gaps = 1'b0;
  int slverr_word = -1;
  bit early_rlast = 1'b0;
  int ar_count = 0;
  int ar_addr_err = 0;
  int ar_stable_err = 0;
  int beat_count = 0;
  int rready_err = 0;

  read_matrix_if axi ();

  read_matrix #(
    .BASE_ADDR (32'h0000_0000),
    .NBLK      (NBLK),
    .NROW      (NROW),
    .NCOL      (NCOL)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .readstart (readstart),
    .readdone  (readdone),
    .readerr   (readerr),
    .Matrix_A  (mat),
    .axi       (axi.master)
  );

  always #5 clk = ~clk;

  // Behavioural slave: samples handshakes at the edge, drives new values 1 time unit later.
  initial begin : slave
    bit          pending;
    int          beat;
    int          held;
    logic [31:0] held_addr;
    logic [31:0] burst_word;
    logic [31:0] hs_addr;
    bit          ar_hs;
    bit          r_hs;
    pending = 0; beat = 0; held = 0; held_addr = '0; burst_word = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    forever begin
      @(posedge clk);
      ar_hs   = axi.arvalid && axi.arready;
      r_hs    = axi.rvalid && axi.rready;
      hs_addr = axi.araddr;
      #1;
      if (!rstn) begin
        pending = 0; beat = 0; held = 0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
      end else begin
        if (r_hs) begin
          beat_count++;
          beat++;
          if (beat == NCOL) pending = 0;
        end
        if (ar_hs) begin
          if (hs_addr !== 32'(ar_count * NCOL * 4)) ar_addr_err++;
          ar_count++;
          pending    = 1;
          burst_word = hs_addr >> 2;
          beat       = 0;
          held       = 0;
        end
        if (axi.arvalid) begin
          if (held > 0 && axi.araddr !== held_addr) ar_stable_err++;
          held_addr = axi.araddr;
          held++;
        end else begin
          held = 0;
        end
        axi.arready = axi.arvalid && (held > ar_wait);
        if (axi.rready && !pending) rready_err++;
        if (pending && beat < NCOL && (!gaps || $urandom_range(0, 1) == 1)) begin
          axi.rvalid = 1'b1;
          axi.rdata  = burst_word + 32'(beat);
          axi.rresp  = (int'(burst_word) + beat == slverr_word) ? 2'b10 : 2'b00;
          axi.rlast  = (early_rlast && burst_word == 0) ? (beat == 5) : (beat == NCOL - 1);
        end else begin
          axi.rvalid = 1'b0;
          axi.rdata  = 32'hDEAD_BEEF;
          axi.rlast  = 1'b0;
        end
      end
    end
  end

  task automatic clear_stats();
    ar_count = 0; ar_addr_err = 0; ar_stable_err = 0; beat_count = 0; rready_err = 0;
  endtask

  // Leaves the bench 1 time unit after the edge that sampled readstart.
  task automatic start_read();
    @(negedge clk);
    readstart = 1'b1;
    @(posedge clk);
    #1;
    readstart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (readdone) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #1;
    vecs++; if (readdone !== 1'b0) begin errs++; $display("FAIL reset_readdone got %b want 0", readdone); end
    vecs++; if (readerr !== 1'b0) begin errs++; $display("FAIL reset_readerr got %b want 0", readerr); end
    vecs++; if (axi.arvalid !== 1'b0) begin errs++; $display("FAIL reset_arvalid got %b want 0", axi.arvalid); end
    vecs++; if (axi.rready !== 1'b0) begin errs++; $display("FAIL reset_rready got %b want 0", axi.rready); end
    vecs++; if (axi.araddr !== 32'h0) begin errs++; $display("FAIL reset_araddr got %h want 00000000", axi.araddr); end
    vecs++; if (mat !== '0) begin errs++; $display("FAIL reset_matrix got nonzero want all zero"); end
    vecs++; if (axi.arlen !== 8'd7) begin errs++; $display("FAIL arlen got %0d want 7", axi.arlen); end
    vecs++; if (axi.arsize !== 3'b010) begin errs++; $display("FAIL arsize got %b want 010", axi.arsize); end
    vecs++; if (axi.arburst !== 2'b01) begin errs++; $display("FAIL arburst got %b want 01", axi.arburst); end
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_wait();
    int cyc; bit ok;
    clear_stats();
    ar_wait = 0; gaps = 0; slverr_word = -1; early_rlast = 0;
    start_read();
    vecs++; if (axi.arvalid !== 1'b1) begin errs++; $display("FAIL zw_arvalid_rise got %b want 1", axi.arvalid); end
    wait_done(1000, cyc, ok);
    // 288 edges after the sampling edge = cycle 290 counting the readstart cycle as cycle 1
    vecs++; if (!ok || cyc != 288) begin errs++; $display("FAIL zw_latency got %0d (done=%b) want 288", cyc, ok); end
    vecs++; if (readerr !== 1'b0) begin errs++; $display("FAIL zw_readerr got %b want 0", readerr); end
    vecs++; if (ar_count != 32 || ar_addr_err != 0) begin errs++; $display("FAIL zw_ar got %0d bursts %0d bad addr want 32 and 0", ar_count, ar_addr_err); end
    vecs++; if (rready_err != 0) begin errs++; $display("FAIL zw_rready_outside got %0d want 0", rready_err); end
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < NROW; r++)
        for (int c = 0; c < NCOL; c++) begin
          vecs++;
          if (mat[b][r][c] !== 32'(b * 64 + r * 8 + c)) begin
            errs++; $display("FAIL zw_mat[%0d][%0d][%0d] got %0d want %0d", b, r, c, mat[b][r][c], b * 64 + r * 8 + c);
          end
        end
  endtask

  task automatic test_ar_stall();
    int cyc; bit ok;
    clear_stats();
    ar_wait = 5; gaps = 0; slverr_word = -1; early_rlast = 0;
    start_read();
    wait_done(2000, cyc, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL stall_done got timeout want readdone"); end
    vecs++; if (ar_stable_err != 0) begin errs++; $display("FAIL stall_stable got %0d changes want 0", ar_stable_err); end
    vecs++; if (ar_count != 32 || ar_addr_err != 0) begin errs++; $display("FAIL stall_ar got %0d bursts %0d bad addr want 32 and 0", ar_count, ar_addr_err); end
    vecs++; if (readerr !== 1'b0) begin errs++; $display("FAIL stall_readerr got %b want 0", readerr); end
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < NROW; r++)
        for (int c = 0; c < NCOL; c++) begin
          vecs++;
          if (mat[b][r][c] !== 32'(b * 64 + r * 8 + c)) begin
            errs++; $display("FAIL stall_mat[%0d][%0d][%0d] got %0d want %0d", b, r, c, mat[b][r][c], b * 64 + r * 8 + c);
          end
        end
    ar_wait = 0;
  endtask

  task automatic test_rvalid_gaps();
    int cyc; bit ok;
    clear_stats();
    ar_wait = 0; gaps = 1; slverr_word = -1; early_rlast = 0;
    start_read();
    wait_done(3000, cyc, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL gaps_done got timeout want readdone"); end
    vecs++; if (beat_count != 256) begin errs++; $display("FAIL gaps_beats got %0d want 256", beat_count); end
    vecs++; if (readerr !== 1'b0) begin errs++; $display("FAIL gaps_readerr got %b want 0", readerr); end
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < NROW; r++)
        for (int c = 0; c < NCOL; c++) begin
          vecs++;
          if (mat[b][r][c] !== 32'(b * 64 + r * 8 + c)) begin
            errs++; $display("FAIL gaps_mat[%0d][%0d][%0d] got %0d want %0d", b, r, c, mat[b][r][c], b * 64 + r * 8 + c);
          end
        end
    gaps = 0;
  endtask

  task automatic test_slverr();
    int cyc; bit ok;
    clear_stats();
    slverr_word = 2 * 64 + 3 * 8 + 4;
    start_read();
    wait_done(1000, cyc, ok);
    vecs++; if (!ok || readerr !== 1'b1) begin errs++; $display("FAIL slverr_flag got %b (done=%b) want 1", readerr, ok); end
    vecs++; if (mat[2][3][4] !== 32'd156) begin errs++; $display("FAIL slverr_data got %0d want 156", mat[2][3][4]); end
    repeat (5) @(posedge clk);
    #1;
    vecs++; if (readerr !== 1'b1) begin errs++; $display("FAIL slverr_sticky got %b want 1", readerr); end
    slverr_word = -1;
    start_read();
    vecs++; if (readerr !== 1'b0) begin errs++; $display("FAIL restart_readerr got %b want 0", readerr); end
    vecs++; if (readdone !== 1'b0) begin errs++; $display("FAIL restart_readdone got %b want 0", readdone); end
    wait_done(1000, cyc, ok);
    vecs++; if (!ok || readerr !== 1'b0) begin errs++; $display("FAIL restart_clean got %b (done=%b) want 0", readerr, ok); end
  endtask

  task automatic test_early_rlast();
    int cyc; bit ok;
    clear_stats();
    early_rlast = 1;
    start_read();
    wait_done(1000, cyc, ok);
    vecs++; if (!ok || readerr !== 1'b1) begin errs++; $display("FAIL rlast_flag got %b (done=%b) want 1", readerr, ok); end
    vecs++; if (beat_count != 256 || ar_count != 32) begin errs++; $display("FAIL rlast_count got %0d beats %0d bursts want 256 and 32", beat_count, ar_count); end
    vecs++; if (mat[0][0][7] !== 32'd7 || mat[0][1][0] !== 32'd8) begin errs++; $display("FAIL rlast_data got %0d,%0d want 7,8", mat[0][0][7], mat[0][1][0]); end
    early_rlast = 0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok;
    int guard;
    clear_stats();
    early_rlast = 1;
    start_read();
    guard = 0;
    while (ar_count < 9 && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    vecs++; if (ar_count < 9) begin errs++; $display("FAIL midrst_reach got %0d bursts want 9", ar_count); end
    repeat (3) @(posedge clk);
    #2;
    vecs++; if (readerr !== 1'b1) begin errs++; $display("FAIL midrst_pre_err got %b want 1", readerr); end
    rstn = 1'b0;
    #1;
    vecs++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin errs++; $display("FAIL midrst_hs got arvalid=%b rready=%b want 0 0", axi.arvalid, axi.rready); end
    vecs++; if (readerr !== 1'b0 || readdone !== 1'b0) begin errs++; $display("FAIL midrst_flags got err=%b done=%b want 0 0", readerr, readdone); end
    vecs++; if (axi.araddr !== 32'h0) begin errs++; $display("FAIL midrst_araddr got %h want 00000000", axi.araddr); end
    vecs++; if (mat !== '0) begin errs++; $display("FAIL midrst_matrix got nonzero want all zero"); end
    early_rlast = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    clear_stats();
    start_read();
    wait_done(1000, cyc, ok);
    vecs++; if (!ok || cyc != 288 || readerr !== 1'b0) begin errs++; $display("FAIL midrst_rerun got %0d cycles err=%b want 288 and 0", cyc, readerr); end
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < NROW; r++)
        for (int c = 0; c < NCOL; c++) begin
          vecs++;
          if (mat[b][r][c] !== 32'(b * 64 + r * 8 + c)) begin
            errs++; $display("FAIL midrst_mat[%0d][%0d][%0d] got %0d want %0d", b, r, c, mat[b][r][c], b * 64 + r * 8 + c);
          end
        end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ar_stall();
    test_rvalid_gaps();
    test_slverr();
    test_early_rlast();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
